// File: rtl/shift_sequencer_pkg.sv
// Shared datapath constants for the shift sequencer: default width,
// sequencer state encoding and the single-step shift direction codes.
package shift_sequencer_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } seq_state_t;

   // Direction is carried as a signed step: +1 moves bits up, -1 moves them down.
   localparam logic signed [1:0] DIR_LEFT  = 2'sb01;
   localparam logic signed [1:0] DIR_RIGHT = 2'sb11;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between a requester and the shift sequencer.
interface shift_sequencer_if #(
   parameter int WIDTH = shift_sequencer_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] shiftAmount;
   logic             shiftType;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, src, shiftAmount, shiftType,
      input  busy, done, result
   );

   modport slave (
      input  start, src, shiftAmount, shiftType,
      output busy, done, result
   );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// Single-bit shifter: moves src one place left or right. Right shifts fill
// the vacated MSB with zero (logical) or with the current MSB (arithmetic);
// left shifts always fill the LSB with zero.
module shift_sequencer_shifter
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0]  src,
   input  logic signed [1:0] shiftDirection,
   input  logic              shiftType,
   output logic [WIDTH-1:0]  dst
);

   logic move_left;
   logic fill_msb;

   assign move_left = (shiftDirection == DIR_LEFT);
   assign fill_msb  = shiftType ? 1'b0 : src[WIDTH-1];

   genvar gi;
   generate
      // Each output bit picks its lower or upper neighbour depending on direction.
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic from_lo;
         logic from_hi;
         if (gi == 0) begin : g_lo_edge
            assign from_lo = 1'b0;
         end else begin : g_lo_mid
            assign from_lo = src[gi-1];
         end
         if (gi == WIDTH - 1) begin : g_hi_edge
            assign from_hi = fill_msb;
         end else begin : g_hi_mid
            assign from_hi = src[gi+1];
         end
         assign dst[gi] = move_left ? from_lo : from_hi;
      end
   endgenerate

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts a signed shift count, saturates its magnitude
// to WIDTH and applies it one bit per clock through the single-bit shifter.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic              clk,
   input logic              reset,
   shift_sequencer_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   seq_state_t        state_reg, state_next;
   logic [WIDTH-1:0]  acc_reg, acc_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              type_reg, type_next;
   logic              right_reg, right_next;
   logic [WIDTH-1:0]  result_reg, result_next;
   logic              busy_reg;
   logic              done_reg;

   logic [WIDTH:0]    amt_ext;
   logic [WIDTH:0]    amt_mag;
   logic [CNT_W-1:0]  amt_count;
   logic signed [1:0] dir;
   logic [WIDTH-1:0]  shifted;

   // Magnitude is formed one bit wider than the operand so the most negative
   // count has a representable absolute value before saturation.
   assign amt_ext   = {bus.shiftAmount[WIDTH-1], bus.shiftAmount};
   assign amt_mag   = amt_ext[WIDTH] ? (~amt_ext + (WIDTH+1)'(1)) : amt_ext;
   assign amt_count = (amt_mag > (WIDTH+1)'(WIDTH)) ? CNT_W'(WIDTH)
                                                    : amt_mag[CNT_W-1:0];

   assign dir = right_reg ? DIR_RIGHT : DIR_LEFT;

   shift_sequencer_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .src            (acc_reg),
      .shiftDirection (dir),
      .shiftType      (type_reg),
      .dst            (shifted)
   );

   // Next-state and datapath selection for the IDLE/SHIFT/DONE sequence.
   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      count_next  = count_reg;
      type_next   = type_reg;
      right_next  = right_reg;
      result_next = result_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               acc_next   = bus.src;
               type_next  = bus.shiftType;
               right_next = bus.shiftAmount[WIDTH-1];
               count_next = amt_count;
               if (amt_count == '0) begin
                  state_next  = ST_DONE;
                  result_next = bus.src;
               end else begin
                  state_next = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            acc_next   = shifted;
            count_next = count_reg - CNT_W'(1);
            if (count_reg == CNT_W'(1)) begin
               state_next  = ST_DONE;
               result_next = shifted;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State registers; busy/done are registered from the next state so they
   // line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         acc_reg    <= '0;
         count_reg  <= '0;
         type_reg   <= 1'b0;
         right_reg  <= 1'b0;
         result_reg <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         count_reg  <= count_next;
         type_reg   <= type_next;
         right_reg  <= right_next;
         result_reg <= result_next;
         busy_reg   <= (state_next != ST_IDLE);
         done_reg   <= (state_next == ST_DONE);
      end
   end

   assign bus.busy   = busy_reg;
   assign bus.done   = done_reg;
   assign bus.result = result_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a driver issues directed and random requests and
// pushes the expected outcome; a negedge monitor checks busy/done/result.
module tb_shift_sequencer;

   localparam int W = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;
   int   op_s   = 1;
   int   op_end = 0;

   typedef struct {
      logic [W-1:0] src;
      logic [W-1:0] amt;
      logic [W-1:0] res;
      int           s;
      int           n;
   } exp_t;

   exp_t exp_q[$];

   shift_sequencer_if #(.WIDTH(W)) bus();

   shift_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference: shift by a signed amount, magnitude capped at W.
   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int amt, input bit logical);
      int n;
      logic [31:0] wide;
      int sv;
      n = (amt < 0) ? -amt : amt;
      if (n > W) n = W;
      if (amt >= 0) begin
         wide = {16'h0, v} << n;
         return wide[W-1:0];
      end
      if (logical) begin
         wide = {16'h0, v} >> n;
         return wide[W-1:0];
      end
      sv = $signed(v);
      sv = sv >>> n;
      return sv[W-1:0];
   endfunction

   function automatic int amt_mag(input logic [W-1:0] amt);
      int a;
      a = int'($signed(amt));
      if (a < 0) a = -a;
      if (a > W) a = W;
      return a;
   endfunction

   // Drive a request in the current (idle) period and record its expectation.
   task automatic issue(input logic [W-1:0] s_src, input logic [W-1:0] s_amt, input bit s_type, output int s, output int n);
      exp_t e;
      bus.start       = 1'b1;
      bus.src         = s_src;
      bus.shiftAmount = s_amt;
      bus.shiftType   = s_type;
      n = amt_mag(s_amt);
      s = cyc + 1;
      e.src = s_src;
      e.amt = s_amt;
      e.res = ref_shift(s_src, int'($signed(s_amt)), s_type);
      e.s   = s;
      e.n   = n;
      exp_q.push_back(e);
      op_s   = s;
      op_end = s + n;
   endtask

   task automatic run_op(input logic [W-1:0] s_src, input logic [W-1:0] s_amt, input bit s_type,
                         input bit poke_busy, input bit poke_done);
      int s;
      int n;
      issue(s_src, s_amt, s_type, s, n);
      tick();
      bus.start       = 1'b0;
      bus.src         = 16'($urandom);
      bus.shiftAmount = 16'($urandom);
      bus.shiftType   = 1'($urandom);
      while (cyc < s + n) begin
         if (poke_busy) begin
            bus.start       = 1'($urandom_range(0, 1));
            bus.src         = 16'hAAAA;
            bus.shiftAmount = 16'($urandom);
         end
         tick();
      end
      bus.start = poke_done;
      tick();
      bus.start = 1'b0;
   endtask

   // Scoreboard monitor: busy window and done timing come from the driver's
   // record of accepted requests.
   always @(negedge clk) begin : monitor
      exp_t e;
      bit   want_done;
      if (mon_en) begin
         want_done = (cyc == op_end) && (exp_q.size() != 0);
         check("busy", 32'(bus.busy), 32'((cyc >= op_s) && (cyc <= op_end)));
         check("done", 32'(bus.done), 32'(want_done));
         if (bus.done && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("result", 32'(bus.result), 32'(e.res));
            check("latency", 32'(cyc - e.s + 1), 32'(e.n + 1));
            $display("op src=%h amt=%h result=%h want=%h latency=%0d", e.src, e.amt, bus.result, e.res, cyc - e.s + 1);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int s;
      int n;
      logic [W-1:0] r_src;
      logic [W-1:0] r_amt;
      int a;
      bus.start       = 1'b0;
      bus.src         = '0;
      bus.shiftAmount = '0;
      bus.shiftType   = 1'b0;

      reset = 1'b1;
      tick();
      bus.start = 1'b1;
      tick();
      check("reset_busy", 32'(bus.busy), 32'(0));
      check("reset_done", 32'(bus.done), 32'(0));
      check("reset_result", 32'(bus.result), 32'(0));
      bus.start = 1'b0;
      reset  = 1'b0;
      mon_en = 1'b1;

      // Directed cases, the first one on the first edge after reset release.
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_op(16'h8000, 16'hFFFD, 1'b0, 1'b0, 1'b0);
      run_op(16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0);
      run_op(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
      run_op(16'h8000, 16'hFFEC, 1'b0, 1'b0, 1'b0);
      run_op(16'h8000, 16'hFFEC, 1'b1, 1'b0, 1'b0);
      run_op(16'hC3A5, 16'h8000, 1'b0, 1'b0, 1'b0);
      run_op(16'h1357, 16'h0003, 1'b1, 1'b1, 1'b1);

      // Abort a shift with reset; no completion may follow.
      issue(16'h0F0F, 16'd10, 1'b0, s, n);
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      reset     = 1'b1;
      bus.start = 1'b1;
      exp_q.delete();
      op_end = cyc;
      tick();
      reset     = 1'b0;
      bus.start = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'(0));
      check("abort_done", 32'(bus.done), 32'(0));
      check("abort_result", 32'(bus.result), 32'(0));
      run_op(16'h00F0, 16'hFFFC, 1'b1, 1'b0, 1'b0);

      // Random requests across small, full-range, zero and saturating counts.
      for (int i = 0; i < 60; i++) begin
         r_src = 16'($urandom);
         case ($urandom_range(0, 3))
            0: begin
               a = int'($urandom_range(0, 20));
               r_amt = $urandom_range(0, 1) ? 16'(-a) : 16'(a);
            end
            1: r_amt = 16'($urandom);
            2: r_amt = 16'h0000;
            default: begin
               a = int'($urandom_range(16, 40));
               r_amt = $urandom_range(0, 1) ? 16'(-a) : 16'(a);
            end
         endcase
         run_op(r_src, r_amt, 1'($urandom), 1'($urandom), 1'($urandom));
      end

      tick();
      tick();
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 16, datapath width in bits.
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have port: src  input  WIDTH  operand, captured on accepted start.
REQ-006 SHALL have port: shiftAmount  input  WIDTH  signed two's-complement count; negative = right, positive = left.
REQ-007 SHALL have port: shiftType  input  1  1 = logical, 0 = arithmetic; captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high in SHIFT and DONE states.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: result  output  WIDTH  shifted value; valid while done is high and held until the next accepted start.

Function
REQ-011 SHALL implement states IDLE, SHIFT, DONE.
REQ-012 In IDLE, start=1 SHALL latch src into accumulator, shiftType into type register, sign(shiftAmount) into direction register, and min(|shiftAmount|, WIDTH) into count.
REQ-013 |shiftAmount| SHALL be computed at WIDTH+1 bits so 16'h8000 yields 32768, saturated to WIDTH.
REQ-014 Accepted start with count 0 SHALL go IDLE->DONE; result SHALL equal src.
REQ-015 Accepted start with count N>0 SHALL go IDLE->SHIFT.
REQ-016 In SHIFT, each cycle SHALL load the accumulator with the single-bit shifter output (direction +1 or -1, latched type) and decrement count.
REQ-017 SHIFT->DONE SHALL occur on the edge where count goes 1->0.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency: done SHALL be high in cycle N+1 after the start-sampling edge; N=0 gives 1 cycle.
REQ-020 Right logical shift SHALL fill with 0; right arithmetic SHALL replicate the latched MSB; left shift SHALL fill with 0 for both types.
REQ-021 start while busy SHALL be ignored; in-flight operation and latched operands SHALL be unaffected.
REQ-022 start high in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE.
REQ-023 Input changes after acceptance SHALL NOT affect the result.
REQ-024 Count WIDTH right-arithmetic SHALL give all bits = src MSB; logical right or any left SHALL give 0.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, count=0.
REQ-026 Reset SHALL take priority over start and over an in-flight SHIFT; the aborted operation SHALL NOT produce done.
REQ-027 First start SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-028 State encoding and the WIDTH default SHALL live in the shared CPU package with other datapath constants.
REQ-029 The block SHALL instantiate the existing single-bit shifter once as its only sub-module (src = accumulator, shiftDirection = +1/-1, shiftType = latched type).
REQ-030 Sequencer logic SHALL be one clocked process plus one combinational next-state process.

Verification
REQ-031 src=FFFF, amt=FFFF, logical -> done at cycle 2, result=7FFF.
REQ-032 src=8000, amt=FFFD (-3), arithmetic -> done at cycle 4, result=F000; busy high cycles 1-4.
REQ-033 src=0001, amt=000F -> done at cycle 16, result=8000; amt=0000 with src=1234 -> done at cycle 1, result=1234.
REQ-034 src=8000, amt=FFEC (-20), arithmetic -> saturates to 16, done at cycle 17, result=FFFF; same with logical -> 0000.
REQ-035 Second start (src=AAAA) during a busy 3-bit shift -> ignored; first result unchanged, single done pulse.
REQ-036 reset asserted mid-SHIFT -> next cycle IDLE, busy=0, result=0000, no done; a new start then completes normally.
